bcd_digit_encoder: RTL

Sequential binary-to-BCD encoder for the calculator's display path. It takes a signed two's-complement result from the arithmetic unit and converts it with a multi-cycle shift-and-add-3 (double dabble) engine. It produces four 4-bit display codes (digit, minus, error, blank) in the code space the 7-segment decoder accepts. It is the producer end of the digit/segment interface and feeds the display decoder directly.

---
 rtl/bcd_digit_encoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bcd_digit_encoder.sv
// Sequential signed binary-to-BCD encoder (double dabble) producing four
// 7-segment display codes: digits 0-9, minus (10), 'E' (11) and blank (12).
module bcd_digit_encoder #(
    parameter int WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] bin_in,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [3:0]              d3,
    output logic [3:0]              d2,
    output logic [3:0]              d1,
    output logic [3:0]              d0
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ABS    = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_FORMAT = 2'd3;

    localparam logic [3:0] CODE_MINUS = 4'd10;
    localparam logic [3:0] CODE_ERR   = 4'd11;
    localparam logic [3:0] CODE_BLANK = 4'd12;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    logic [1:0]              state;
    logic signed [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0]        mag;
    logic [15:0]             bcd;
    logic [CNT_W-1:0]        cnt;
    logic                    neg;
    logic                    ovf_int;
    logic [WIDTH+15:0]       shift_vec;

    // Magnitude as unsigned WIDTH bits; the most negative input wraps to 2^(WIDTH-1) exactly.
    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return u[WIDTH-1] ? (~u + 1'b1) : u;
    endfunction

    function automatic logic out_of_range(input logic sgn, input logic [WIDTH-1:0] m);
        logic [31:0] m_ext;
        m_ext = 32'(m);
        return sgn ? (m_ext > 32'd999) : (m_ext > 32'd9999);
    endfunction

    function automatic logic [15:0] add3_nibbles(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
        end
        return r;
    endfunction

    // Blank zeros left of the leading digit; the minus sign sits just left of it.
    function automatic logic [15:0] format_digits(input logic [15:0] b, input logic sgn);
        logic [15:0] r;
        int          msd;
        msd = 0;
        for (int i = 1; i < 4; i++) begin
            if (b[4*i +: 4] != 4'd0) msd = i;
        end
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (i > msd) ? CODE_BLANK : b[4*i +: 4];
        end
        if (sgn && msd < 3) r[4*(msd+1) +: 4] = CODE_MINUS;
        return r;
    endfunction

    always_comb begin
        shift_vec = {add3_nibbles(bcd), mag} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bin_reg <= '0;
            mag     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            ovf_int <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            d3      <= CODE_BLANK;
            d2      <= CODE_BLANK;
            d1      <= CODE_BLANK;
            d0      <= CODE_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_reg <= bin_in;
                        state   <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    mag     <= abs_mag(bin_reg);
                    neg     <= bin_reg[WIDTH-1];
                    ovf_int <= out_of_range(bin_reg[WIDTH-1], abs_mag(bin_reg));
                    bcd     <= '0;
                    cnt     <= CNT_LOAD;
                    busy    <= 1'b1;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Carry out of the top BCD nibble drops off here; it only happens on overflow.
                    {bcd, mag} <= shift_vec;
                    cnt        <= cnt - 1'b1;
                    if (cnt == CNT_LAST) state <= ST_FORMAT;
                end
                ST_FORMAT: begin
                    if (ovf_int) begin
                        d3  <= CODE_ERR;
                        d2  <= CODE_BLANK;
                        d1  <= CODE_BLANK;
                        d0  <= CODE_BLANK;
                        ovf <= 1'b1;
                    end else begin
                        {d3, d2, d1, d0} <= format_digits(bcd, neg);
                        ovf              <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
